// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM timer: register map, CTRL/STATUS
// bit positions and reset values.
package pwm_pkg;

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned DATA_W = 16;

  // Word addresses; DUTY[k] lives at ADDR_DUTY0 + k
  localparam logic [ADR_W-1:0] ADDR_CTRL    = 4'd0;
  localparam logic [ADR_W-1:0] ADDR_DIVISOR = 4'd1;
  localparam logic [ADR_W-1:0] ADDR_PERIOD  = 4'd2;
  localparam logic [ADR_W-1:0] ADDR_STATUS  = 4'd3;
  localparam logic [ADR_W-1:0] ADDR_DUTY0   = 4'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_CONT      = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned CTRL_CENTER    = 3;
  localparam int unsigned CTRL_FORCE_UPD = 4;
  localparam int unsigned CTRL_CH_EN_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STAT_PEND = 0;
  localparam int unsigned STAT_DONE = 1;

  // Reset values
  localparam int unsigned RST_DIVISOR = 1;
  localparam int unsigned RST_PERIOD  = 1000;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every DIVISOR cycles (0 and 1 both tick every
// cycle); freezes its count while hold is asserted.
module pwm_prescaler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [CNT_W-1:0] divisor,
  output logic             tick_c
);

  logic [CNT_W-1:0] div_cnt;

  // Terminal count detect; >= keeps it safe if the divisor shrinks under a running count
  always_comb begin
    tick_c = 1'b0;
    if (!hold) begin
      tick_c = (divisor <= CNT_W'(1)) || (div_cnt >= divisor - CNT_W'(1));
    end
  end

  // Divider count, cleared on each tick and held while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!hold) begin
      div_cnt <= tick_c ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM timer with a shared prescaler and period counter,
// double-buffered divisor/period/duty, one-shot or continuous operation and a
// sticky period interrupt, configured over a Wishbone slave port.
// Optional feature macro: PWM_CENTER_ALIGN_EN (up/down centre-aligned counting).
module pwm_multi_timer
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [ADR_W-1:0]  i_wb_adr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_wb_ack,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [N_CH-1:0]   o_pwm,
  output logic              o_irq
);

`ifdef PWM_CENTER_ALIGN_EN
  localparam bit CENTER_EN = 1'b1;
`else
  localparam bit CENTER_EN = 1'b0;
`endif

  logic             en, cont, irq_en, center, upd_req, pend, done, down;
  logic [N_CH-1:0]  ch_en;
  logic [CNT_W-1:0] div_sh, div_act, per_sh, per_act, cnt;
  logic [CNT_W-1:0] duty_sh  [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];

  logic             acc_c, wr_c, wr_ctrl_c, wr_stat_c, tick_c, pe_c, oneshot_c, copy_c;
  logic             en_n, irq_en_n, pend_n, done_n, down_n;
  logic [CNT_W-1:0] cnt_n, wdata_c;
  logic [DATA_W-1:0] rd_c;
  logic [N_CH-1:0]  pwm_c;

  assign acc_c     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_c      = acc_c & i_wb_we;
  assign wr_ctrl_c = wr_c & (i_wb_adr == ADDR_CTRL);
  assign wr_stat_c = wr_c & (i_wb_adr == ADDR_STATUS);
  assign wdata_c   = CNT_W'(i_wb_data);

  pwm_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk     (i_clk),
    .rst     (i_rst),
    .hold    (~en),
    .divisor (div_act),
    .tick_c  (tick_c)
  );

  // Period counter: edge-aligned wrap, or up/down with end-of-period at the bottom
  always_comb begin
    cnt_n  = cnt;
    down_n = down;
    pe_c   = 1'b0;
    if (per_act == '0) begin
      cnt_n  = '0;
      down_n = 1'b0;
    end else if (tick_c) begin
      if (center) begin
        if (!down) begin
          if (cnt >= per_act - CNT_W'(1)) begin
            down_n = 1'b1;
            cnt_n  = per_act - CNT_W'(1);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (cnt == '0) begin
          down_n = 1'b0;
          pe_c   = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end else begin
        down_n = 1'b0;
        if (cnt >= per_act - CNT_W'(1)) begin
          cnt_n = '0;
          pe_c  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
    oneshot_c = pe_c & ~cont;
    if (oneshot_c) begin
      cnt_n  = '0;
      down_n = 1'b0;
    end
    copy_c = pe_c | ~en | upd_req;
  end

  // Control/status next values; hardware set of pend/done wins over W1C
  always_comb begin
    en_n = en;
    if (wr_ctrl_c) begin
      en_n = i_wb_data[CTRL_EN];
    end else if (oneshot_c) begin
      en_n = 1'b0;
    end
    irq_en_n = wr_ctrl_c ? i_wb_data[CTRL_IRQ_EN] : irq_en;
    pend_n   = (pend & ~(wr_stat_c & i_wb_data[STAT_PEND])) | pe_c;
    done_n   = (done & ~(wr_stat_c & i_wb_data[STAT_DONE])) | oneshot_c;
  end

  // Register read mux; unmapped addresses read zero
  always_comb begin
    rd_c = '0;
    case (i_wb_adr)
      ADDR_CTRL: begin
        rd_c[CTRL_EN]                 = en;
        rd_c[CTRL_CONT]               = cont;
        rd_c[CTRL_IRQ_EN]             = irq_en;
        rd_c[CTRL_CENTER]             = center;
        rd_c[CTRL_CH_EN_LSB +: N_CH]  = ch_en;
      end
      ADDR_DIVISOR: rd_c = DATA_W'(div_sh);
      ADDR_PERIOD:  rd_c = DATA_W'(per_sh);
      ADDR_STATUS: begin
        rd_c[STAT_PEND] = pend;
        rd_c[STAT_DONE] = done;
      end
      default: begin
        for (int k = 0; k < int'(N_CH); k++) begin
          if (i_wb_adr == ADR_W'(ADDR_DUTY0 + k)) rd_c = DATA_W'(duty_sh[k]);
        end
      end
    endcase
  end

  // Per-channel compare against the active duty
  always_comb begin
    pwm_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      pwm_c[k] = en & ch_en[k] & (per_act != '0) & (cnt < duty_act[k]);
    end
  end

  // All state: bus, configuration, shadow/active copies, counter and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_pwm     <= '0;
      o_irq     <= 1'b0;
      en        <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      center    <= 1'b0;
      ch_en     <= '0;
      upd_req   <= 1'b0;
      pend      <= 1'b0;
      done      <= 1'b0;
      down      <= 1'b0;
      cnt       <= '0;
      div_sh    <= CNT_W'(RST_DIVISOR);
      div_act   <= CNT_W'(RST_DIVISOR);
      per_sh    <= CNT_W'(RST_PERIOD);
      per_act   <= CNT_W'(RST_PERIOD);
      for (int k = 0; k < int'(N_CH); k++) begin
        duty_sh[k]  <= '0;
        duty_act[k] <= '0;
      end
    end else begin
      o_wb_ack  <= acc_c;
      o_wb_data <= acc_c ? rd_c : '0;
      en        <= en_n;
      irq_en    <= irq_en_n;
      pend      <= pend_n;
      done      <= done_n;
      upd_req   <= wr_ctrl_c & i_wb_data[CTRL_FORCE_UPD];
      if (wr_ctrl_c) begin
        cont   <= i_wb_data[CTRL_CONT];
        center <= CENTER_EN & i_wb_data[CTRL_CENTER];
        ch_en  <= i_wb_data[CTRL_CH_EN_LSB +: N_CH];
      end
      if (wr_c && i_wb_adr == ADDR_DIVISOR) div_sh <= wdata_c;
      if (wr_c && i_wb_adr == ADDR_PERIOD)  per_sh <= wdata_c;
      for (int k = 0; k < int'(N_CH); k++) begin
        if (wr_c && i_wb_adr == ADR_W'(ADDR_DUTY0 + k)) duty_sh[k] <= wdata_c;
      end
      if (copy_c) begin
        div_act <= div_sh;
        per_act <= per_sh;
        for (int k = 0; k < int'(N_CH); k++) duty_act[k] <= duty_sh[k];
      end
      cnt   <= cnt_n;
      down  <= down_n;
      o_pwm <= pwm_c;
      o_irq <= pend_n & irq_en_n;
    end
  end

endmodule
